ysyx_22040125_lsu: RTL

YSYX_22040125_LSU -- requirements
Module: ysyx_22040125_lsu

---
 rtl/ysyx_22040125_lsu_pkg.sv | 37 +++
 rtl/ysyx_22040125_lsu_decode.sv | 60 ++++++
 rtl/ysyx_22040125_lsu.sv | 128 ++++++++++++
 3 files changed

// File: rtl/ysyx_22040125_lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, RV64I funct3 codes
// and the one-hot access-type encodings presented to the data RAM.
package ysyx_22040125_lsu_pkg;

  typedef enum logic [1:0] {StIdle, StIssue, StResp} lsu_state_e;

  localparam logic [2:0] Funct3Lb  = 3'b000;
  localparam logic [2:0] Funct3Lh  = 3'b001;
  localparam logic [2:0] Funct3Lw  = 3'b010;
  localparam logic [2:0] Funct3Ld  = 3'b011;
  localparam logic [2:0] Funct3Lbu = 3'b100;
  localparam logic [2:0] Funct3Lhu = 3'b101;
  localparam logic [2:0] Funct3Lwu = 3'b110;
  localparam logic [2:0] Funct3Bad = 3'b111;
  localparam logic [2:0] Funct3Sb  = 3'b000;
  localparam logic [2:0] Funct3Sh  = 3'b001;
  localparam logic [2:0] Funct3Sw  = 3'b010;
  localparam logic [2:0] Funct3Sd  = 3'b011;

  // Load type, bits [5:0] = lb, lbu, lh, lhu, lw, lwu; all-zero means ld.
  localparam logic [5:0] LBhwLb  = 6'b100000;
  localparam logic [5:0] LBhwLbu = 6'b010000;
  localparam logic [5:0] LBhwLh  = 6'b001000;
  localparam logic [5:0] LBhwLhu = 6'b000100;
  localparam logic [5:0] LBhwLw  = 6'b000010;
  localparam logic [5:0] LBhwLwu = 6'b000001;
  localparam logic [5:0] LBhwLd  = 6'b000000;

  // Store type, bits [2:0] = sb, sh, sw; all-zero means sd.
  localparam logic [2:0] SBhwdSb = 3'b100;
  localparam logic [2:0] SBhwdSh = 3'b010;
  localparam logic [2:0] SBhwdSw = 3'b001;
  localparam logic [2:0] SBhwdSd = 3'b000;

  localparam logic [31:0] RamBaseDefault = 32'h8000_0000;

endpackage

// File: rtl/ysyx_22040125_lsu_decode.sv
// Combinational decode of a memory request into RAM access types and a fault flag
// (illegal funct3, load/store ambiguity, misalignment, address outside the RAM window).
module ysyx_22040125_lsu_decode
  import ysyx_22040125_lsu_pkg::*;
#(
  parameter logic [31:0] RamBase  = RamBaseDefault,
  parameter logic [31:0] RamBytes = 32'd1600000
) (
  input  logic [63:0] addr_i,
  input  logic [2:0]  funct3_i,
  input  logic        is_load_i,
  input  logic        is_store_i,
  output logic [5:0]  l_bhw_o,
  output logic [2:0]  s_bhwd_o,
  output logic        fault_o
);

  localparam logic [63:0] RamLo = {32'd0, RamBase};
  localparam logic [63:0] RamHi = RamLo + {32'd0, RamBytes} - 64'd1;

  logic misaligned;
  logic out_of_range;

  always_comb begin
    l_bhw_o  = LBhwLd;
    s_bhwd_o = SBhwdSd;
    if (is_load_i) begin
      case (funct3_i)
        Funct3Lb:  l_bhw_o = LBhwLb;
        Funct3Lbu: l_bhw_o = LBhwLbu;
        Funct3Lh:  l_bhw_o = LBhwLh;
        Funct3Lhu: l_bhw_o = LBhwLhu;
        Funct3Lw:  l_bhw_o = LBhwLw;
        Funct3Lwu: l_bhw_o = LBhwLwu;
        default:   l_bhw_o = LBhwLd;
      endcase
    end else if (is_store_i) begin
      case (funct3_i)
        Funct3Sb: s_bhwd_o = SBhwdSb;
        Funct3Sh: s_bhwd_o = SBhwdSh;
        Funct3Sw: s_bhwd_o = SBhwdSw;
        default:  s_bhwd_o = SBhwdSd;
      endcase
    end

    // funct3[1:0] gives the access size for both loads and stores.
    case (funct3_i[1:0])
      2'b01:   misaligned = addr_i[0];
      2'b10:   misaligned = |addr_i[1:0];
      2'b11:   misaligned = |addr_i[2:0];
      default: misaligned = 1'b0;
    endcase

    out_of_range = (addr_i < RamLo) || (addr_i > RamHi);

    fault_o = (funct3_i == Funct3Bad) || (is_store_i && funct3_i[2]) ||
              (is_load_i == is_store_i) || misaligned || out_of_range;
  end

endmodule

// File: rtl/ysyx_22040125_lsu.sv
// Load/store unit: accepts one memory op from EX, strobes the data RAM for one cycle,
// then holds the response toward WB until it is taken. Faulting ops skip the RAM.
module ysyx_22040125_lsu
  import ysyx_22040125_lsu_pkg::*;
#(
  parameter logic [31:0] RAM_BASE  = RamBaseDefault,
  parameter logic [31:0] RAM_BYTES = 32'd1600000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [63:0] ex_addr,
  input  logic [63:0] ex_wdata,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_is_load,
  input  logic        ex_is_store,
  input  logic [4:0]  ex_rd,
  output logic [31:0] ram_addr,
  output logic [63:0] wdata,
  output logic [5:0]  l_bhw,
  output logic [2:0]  s_bhwd,
  output logic        data_wen,
  output logic        data_ren,
  input  logic [63:0] rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [63:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        wb_fault
);

  lsu_state_e  state_q, state_d;
  logic [31:0] ram_addr_q, ram_addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [5:0]  l_bhw_q, l_bhw_d;
  logic [2:0]  s_bhwd_q, s_bhwd_d;
  logic [4:0]  rd_q, rd_d;
  logic        is_load_q, is_load_d;
  logic        fault_q, fault_d;

  logic [5:0]  dec_l_bhw;
  logic [2:0]  dec_s_bhwd;
  logic        dec_fault;
  logic        accept;

  ysyx_22040125_lsu_decode #(
    .RamBase  (RAM_BASE),
    .RamBytes (RAM_BYTES)
  ) u_decode (
    .addr_i     (ex_addr),
    .funct3_i   (ex_funct3),
    .is_load_i  (ex_is_load),
    .is_store_i (ex_is_store),
    .l_bhw_o    (dec_l_bhw),
    .s_bhwd_o   (dec_s_bhwd),
    .fault_o    (dec_fault)
  );

  always_comb begin
    // Gated by rst_n so nothing is accepted until the first edge after reset release.
    ex_ready = rst_n && ((state_q == StIdle) || ((state_q == StResp) && wb_ready));
    accept   = ex_valid && ex_ready;

    state_d    = state_q;
    ram_addr_d = ram_addr_q;
    wdata_d    = wdata_q;
    l_bhw_d    = l_bhw_q;
    s_bhwd_d   = s_bhwd_q;
    rd_d       = rd_q;
    is_load_d  = is_load_q;
    fault_d    = fault_q;

    if (accept) begin
      ram_addr_d = ex_addr[31:0];
      wdata_d    = ex_wdata;
      l_bhw_d    = dec_l_bhw;
      s_bhwd_d   = dec_s_bhwd;
      rd_d       = ex_rd;
      is_load_d  = ex_is_load;
      fault_d    = dec_fault;
    end

    case (state_q)
      StIdle:  if (accept) state_d = dec_fault ? StResp : StIssue;
      StIssue: state_d = StResp;
      StResp: begin
        if (wb_ready) state_d = accept ? (dec_fault ? StResp : StIssue) : StIdle;
      end
      default: state_d = StIdle;
    endcase

    data_ren = (state_q == StIssue) && is_load_q;
    data_wen = (state_q == StIssue) && !is_load_q;
    wb_valid = (state_q == StResp);
    wb_data  = (wb_valid && is_load_q && !fault_q) ? rdata : 64'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ram_addr_q <= 32'd0;
      wdata_q    <= 64'd0;
      l_bhw_q    <= 6'd0;
      s_bhwd_q   <= 3'd0;
      rd_q       <= 5'd0;
      is_load_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ram_addr_q <= ram_addr_d;
      wdata_q    <= wdata_d;
      l_bhw_q    <= l_bhw_d;
      s_bhwd_q   <= s_bhwd_d;
      rd_q       <= rd_d;
      is_load_q  <= is_load_d;
      fault_q    <= fault_d;
    end
  end

  assign ram_addr = ram_addr_q;
  assign wdata    = wdata_q;
  assign l_bhw    = l_bhw_q;
  assign s_bhwd   = s_bhwd_q;
  assign wb_rd    = rd_q;
  assign wb_fault = fault_q;

endmodule
